// File: rtl/msg_chnl_arbiter_if.sv
// Four-phase message channel: src/dst/dat/red fields
// qualified by req and completed by ack.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

interface msg_chnl_arbiter_if #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
);
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (
    output src, dst, dat, red, req,
    input  ack
  );

  modport slave (
    input  src, dst, dat, red, req,
    output ack
  );
endinterface

// File: rtl/msg_chnl_arbiter.sv
// Two-way round-robin arbiter onto one four-phase
// message channel; winner's message is latched.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module msg_chnl_arbiter #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) (
  input  logic               src_clk,
  input  logic               reset,
  msg_chnl_arbiter_if.slave  i0,
  msg_chnl_arbiter_if.slave  i1,
  msg_chnl_arbiter_if.master o0,
  output logic               gnt,
  output logic               busy,
  output logic               err,
  output logic [7:0]         cnt0,
  output logic [7:0]         cnt1
);
  typedef enum logic [1:0] {
    IDLE, REQ, DROP, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [ASZ-1:0] src_q, src_d;
  logic [ASZ-1:0] dst_q, dst_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic [RSZ-1:0] red_q, red_d;
  logic           req_q, req_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           gnt_q, gnt_d;
  logic           last_q, last_d;
  logic           err_q, err_d;
  logic [7:0]     cnt0_q, cnt0_d;
  logic [7:0]     cnt1_q, cnt1_d;
  logic           any_req;
  logic           pick;
  logic           win_req;

  assign any_req = i0.req | i1.req;
  // A tie goes to whoever did not win last time
  assign pick    = (i0.req & i1.req) ? ~last_q
                                     : i1.req;
  assign win_req = gnt_q ? i1.req : i0.req;

  always_ff @(posedge src_clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      dat_q   <= '0;
      red_q   <= '0;
      req_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      dat_q   <= dat_d;
      red_q   <= red_d;
      req_q   <= req_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    dat_d   = dat_q;
    red_d   = red_q;
    req_d   = req_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    unique case (state_q)
      IDLE: begin
        if (o0.ack) begin
          if (any_req) err_d = 1'b1;
        end else if (any_req) begin
          state_d = REQ;
          gnt_d   = pick;
          req_d   = 1'b1;
          src_d   = pick ? i1.src : i0.src;
          dst_d   = pick ? i1.dst : i0.dst;
          dat_d   = pick ? i1.dat : i0.dat;
          red_d   = pick ? i1.red : i0.red;
        end
      end
      REQ: begin
        if (o0.ack) begin
          req_d   = 1'b0;
          state_d = DROP;
        end
      end
      DROP: begin
        if (!o0.ack) begin
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (o0.ack) err_d = 1'b1;
        if (!win_req) begin
          ack0_d  = 1'b0;
          ack1_d  = 1'b0;
          last_d  = gnt_q;
          state_d = IDLE;
          if (gnt_q) cnt1_d = cnt1_q + 8'd1;
          else       cnt0_d = cnt0_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o0.src = src_q;
  assign o0.dst = dst_q;
  assign o0.dat = dat_q;
  assign o0.red = red_q;
  assign o0.req = req_q;
  assign i0.ack = ack0_q;
  assign i1.ack = ack1_q;
  assign gnt    = gnt_q;
  assign busy   = (state_q != IDLE);
  assign err    = err_q;
  assign cnt0   = cnt0_q;
  assign cnt1   = cnt1_q;
endmodule

// File: tb/tb_msg_chnl_arbiter.sv
// Bench for msg_chnl_arbiter: directed scenarios plus
// random traffic against a transaction-level model.
module tb_msg_chnl_arbiter;
  localparam int ASZ = 8;
  localparam int DSZ = 16;
  localparam int RSZ = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gnt, busy, err;
  logic [7:0] cnt0, cnt1;
  int         checks = 0;
  int         errors = 0;
  int         ec0 = 0;
  int         ec1 = 0;

  logic [ASZ-1:0] ms_src [2];
  logic [ASZ-1:0] ms_dst [2];
  logic [DSZ-1:0] ms_dat [2];
  logic [RSZ-1:0] ms_red [2];

  msg_chnl_arbiter_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) i0_if ();
  msg_chnl_arbiter_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) i1_if ();
  msg_chnl_arbiter_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) o0_if ();

  msg_chnl_arbiter #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .src_clk (clk),
    .reset   (reset),
    .i0      (i0_if),
    .i1      (i1_if),
    .o0      (o0_if),
    .gnt     (gnt),
    .busy    (busy),
    .err     (err),
    .cnt0    (cnt0),
    .cnt1    (cnt1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int k, input logic [ASZ-1:0] s,
                         input logic [ASZ-1:0] d, input logic [DSZ-1:0] t,
                         input logic [RSZ-1:0] r);
    if (k == 0) begin
      i0_if.src = s; i0_if.dst = d; i0_if.dat = t; i0_if.red = r;
    end else begin
      i1_if.src = s; i1_if.dst = d; i1_if.dat = t; i1_if.red = r;
    end
  endtask

  task automatic set_req(input int k, input logic v);
    if (k == 0) i0_if.req = v;
    else        i1_if.req = v;
  endtask

  // Downstream acks at once, then requester k drops its request.
  task automatic serve(input int k);
    o0_if.ack = 1'b1;
    step();
    o0_if.ack = 1'b0;
    step();
    set_req(k, 1'b0);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ec0 = 0;
    ec1 = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({o0_if.req, i0_if.ack, i1_if.ack, err, busy, gnt} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 000000",
               {o0_if.req, i0_if.ack, i1_if.ack, err, busy, gnt});
    end
    checks++;
    if ({cnt0, cnt1} !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h exp 0000", {cnt0, cnt1});
    end
    checks++;
    if ({o0_if.src, o0_if.dst, o0_if.dat, o0_if.red} !== '0) begin
      errors++;
      $display("FAIL reset_fields got %h exp 0",
               {o0_if.src, o0_if.dst, o0_if.dat, o0_if.red});
    end
    reset = 1'b0;
    ec0 = 0;
    ec1 = 0;
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 10; p++) begin
      set_msg(0, 8'h10, 8'h20, 16'h100 + 16'(p), 4'h1);
      set_msg(1, 8'h11, 8'h21, 16'h200 + 16'(p), 4'h2);
      set_req(0, 1'b1);
      set_req(1, 1'b1);
      step();
      checks++;
      if (o0_if.req !== 1'b1 || gnt !== 1'b0 || o0_if.dat !== 16'h100 + 16'(p)) begin
        errors++;
        $display("FAIL b2b_first pair %0d got req=%b gnt=%b dat=%h exp 1 0 %h",
                 p, o0_if.req, gnt, o0_if.dat, 16'h100 + 16'(p));
      end
      serve(0);
      ec0++;
      step();
      checks++;
      if (o0_if.req !== 1'b1 || gnt !== 1'b1 || o0_if.dat !== 16'h200 + 16'(p)) begin
        errors++;
        $display("FAIL b2b_second pair %0d got req=%b gnt=%b dat=%h exp 1 1 %h",
                 p, o0_if.req, gnt, o0_if.dat, 16'h200 + 16'(p));
      end
      serve(1);
      ec1++;
    end
    checks++;
    if (cnt0 !== 8'd10 || cnt1 !== 8'd10) begin
      errors++;
      $display("FAIL b2b_cnt got %0d %0d exp 10 10", cnt0, cnt1);
    end
  endtask

  task automatic test_single();
    set_msg(0, 8'h01, 8'h02, 16'h0005, 4'h3);
    set_req(0, 1'b1);
    step();
    checks++;
    if (o0_if.req !== 1'b1 || o0_if.dat !== 16'h5 || o0_if.dst !== 8'h2 || gnt !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got req=%b dat=%h dst=%h gnt=%b exp 1 5 2 0",
               o0_if.req, o0_if.dat, o0_if.dst, gnt);
    end
    o0_if.ack = 1'b1;
    step();
    checks++;
    if (o0_if.req !== 1'b0 || i0_if.ack !== 1'b0) begin
      errors++;
      $display("FAIL single_drop got req=%b ack0=%b exp 0 0", o0_if.req, i0_if.ack);
    end
    o0_if.ack = 1'b0;
    step();
    checks++;
    if (i0_if.ack !== 1'b1 || i1_if.ack !== 1'b0) begin
      errors++;
      $display("FAIL single_ack got ack0=%b ack1=%b exp 1 0", i0_if.ack, i1_if.ack);
    end
    set_req(0, 1'b0);
    step();
    ec0++;
    checks++;
    if (i0_if.ack !== 1'b0 || cnt0 !== 8'(ec0) || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_done got ack0=%b cnt0=%0d busy=%b err=%b exp 0 %0d 0 0",
               i0_if.ack, cnt0, busy, err, ec0);
    end
  endtask

  task automatic test_drop_in_req();
    set_msg(0, 8'h0a, 8'h07, 16'h0033, 4'h5);
    set_req(0, 1'b1);
    step();
    set_req(0, 1'b0);
    set_msg(0, 8'hff, 8'hff, 16'hffff, 4'hf);
    step();
    checks++;
    if (o0_if.req !== 1'b1 || o0_if.dat !== 16'h33 || o0_if.dst !== 8'h07) begin
      errors++;
      $display("FAIL dropreq_hold got req=%b dat=%h dst=%h exp 1 33 07",
               o0_if.req, o0_if.dat, o0_if.dst);
    end
    o0_if.ack = 1'b1;
    step();
    o0_if.ack = 1'b0;
    step();
    checks++;
    if (i0_if.ack !== 1'b1) begin
      errors++;
      $display("FAIL dropreq_ack got %b exp 1", i0_if.ack);
    end
    step();
    ec0++;
    checks++;
    if (i0_if.ack !== 1'b0 || cnt0 !== 8'(ec0)) begin
      errors++;
      $display("FAIL dropreq_done got ack0=%b cnt0=%0d exp 0 %0d", i0_if.ack, cnt0, ec0);
    end
  endtask

  task automatic test_ack_stall();
    o0_if.ack = 1'b1;
    set_msg(1, 8'h31, 8'h32, 16'h0077, 4'h6);
    set_req(1, 1'b1);
    step();
    checks++;
    if (o0_if.req !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL stall_err got req=%b err=%b exp 0 1", o0_if.req, err);
    end
    step();
    checks++;
    if (o0_if.req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got req=%b busy=%b exp 0 0", o0_if.req, busy);
    end
    o0_if.ack = 1'b0;
    step();
    checks++;
    if (o0_if.req !== 1'b1 || gnt !== 1'b1 || o0_if.dat !== 16'h77 || err !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got req=%b gnt=%b dat=%h err=%b exp 1 1 77 1",
               o0_if.req, gnt, o0_if.dat, err);
    end
    serve(1);
    ec1++;
    checks++;
    if (cnt1 !== 8'(ec1) || err !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got cnt1=%0d err=%b exp %0d 1", cnt1, err, ec1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_msg(0, 8'h41, 8'h42, 16'h0099, 4'h7);
    set_req(0, 1'b1);
    step();
    checks++;
    if (o0_if.req !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got req=%b exp 1", o0_if.req);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({o0_if.req, i0_if.ack, i1_if.ack, busy} !== 4'b0 || {cnt0, cnt1} !== 16'h0) begin
      errors++;
      $display("FAIL rmid_abort got ctl=%b cnt=%h exp 0000 0000",
               {o0_if.req, i0_if.ack, i1_if.ack, busy}, {cnt0, cnt1});
    end
    reset = 1'b0;
    ec0 = 0;
    ec1 = 0;
    step();
    checks++;
    if (o0_if.req !== 1'b1 || gnt !== 1'b0 || o0_if.dat !== 16'h99) begin
      errors++;
      $display("FAIL rmid_regrant got req=%b gnt=%b dat=%h exp 1 0 99",
               o0_if.req, gnt, o0_if.dat);
    end
    serve(0);
    ec0++;
    checks++;
    if (cnt0 !== 8'(ec0) || err !== 1'b0) begin
      errors++;
      $display("FAIL rmid_done got cnt0=%0d err=%b exp %0d 0", cnt0, err, ec0);
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 256; n++) begin
      set_msg(1, 8'(n), 8'(n + 1), 16'(n), 4'(n));
      set_req(1, 1'b1);
      step();
      serve(1);
      ec1++;
      if (n == 254) begin
        checks++;
        if (cnt1 !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255 got %0d exp 255", cnt1);
        end
      end
    end
    checks++;
    if (cnt1 !== 8'(ec1) || cnt0 !== 8'(ec0) || err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done got cnt1=%0d cnt0=%0d err=%b exp %0d %0d 0",
               cnt1, cnt0, err, 8'(ec1), 8'(ec0));
    end
  endtask

  task automatic test_random();
    logic r0p, r1p, ackp, a0p, a1p, own_prev, own_now;
    logic rk, ak;
    bit   free, last, own, w;
    int   mc0, mc1, busyc;
    free = 1'b1; last = 1'b1; own = 1'b0;
    mc0 = 0; mc1 = 0; busyc = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r0p = i0_if.req; r1p = i1_if.req; ackp = o0_if.ack;
      a0p = i0_if.ack; a1p = i1_if.ack;
      step();
      if (free && !ackp && (r0p || r1p)) begin
        w = (r0p && r1p) ? !last : r1p;
        checks++;
        if (o0_if.req !== 1'b1 || gnt !== w) begin
          errors++;
          $display("FAIL rnd_grant cyc %0d got req=%b gnt=%b exp 1 %b", c, o0_if.req, gnt, w);
        end
        checks++;
        if ({o0_if.src, o0_if.dst, o0_if.dat, o0_if.red} !==
            {ms_src[w], ms_dst[w], ms_dat[w], ms_red[w]}) begin
          errors++;
          $display("FAIL rnd_msg cyc %0d got %h exp %h", c,
                   {o0_if.src, o0_if.dst, o0_if.dat, o0_if.red},
                   {ms_src[w], ms_dst[w], ms_dat[w], ms_red[w]});
        end
        free = 1'b0; own = w; busyc = 0;
      end else if (free) begin
        checks++;
        if (o0_if.req !== 1'b0 || i0_if.ack !== 1'b0 || i1_if.ack !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle cyc %0d got req=%b acks=%b%b exp 0 00",
                   c, o0_if.req, i0_if.ack, i1_if.ack);
        end
      end else begin
        busyc++;
        own_prev = own ? a1p : a0p;
        own_now  = own ? i1_if.ack : i0_if.ack;
        checks++;
        if ((own ? i0_if.ack : i1_if.ack) !== 1'b0) begin
          errors++;
          $display("FAIL rnd_other_ack cyc %0d got 1 exp 0", c);
        end
        if (own_now === 1'b1 && own_prev !== 1'b1) begin
          checks++;
          if (o0_if.req !== 1'b0 || ackp !== 1'b0) begin
            errors++;
            $display("FAIL rnd_handshake cyc %0d got req=%b ack=%b exp 0 0", c, o0_if.req, ackp);
          end
        end
        if (own_now !== 1'b1 && own_prev === 1'b1) begin
          if (own) mc1++;
          else     mc0++;
          last = own; free = 1'b1;
          checks++;
          if (cnt0 !== 8'(mc0) || cnt1 !== 8'(mc1)) begin
            errors++;
            $display("FAIL rnd_cnt cyc %0d got %0d %0d exp %0d %0d",
                     c, cnt0, cnt1, 8'(mc0), 8'(mc1));
          end
        end
        if (busyc > 60) begin
          checks++;
          errors++;
          $display("FAIL rnd_timeout cyc %0d transaction did not complete", c);
          break;
        end
      end
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL rnd_err cyc %0d got 1 exp 0", c);
      end
      for (int k = 0; k < 2; k++) begin
        rk = k ? i1_if.req : i0_if.req;
        ak = k ? i1_if.ack : i0_if.ack;
        if (!rk && !ak && $urandom_range(0, 3) == 0) begin
          ms_src[k] = ASZ'($urandom);
          ms_dst[k] = ASZ'($urandom);
          ms_dat[k] = DSZ'($urandom);
          ms_red[k] = RSZ'($urandom);
          set_msg(k, ms_src[k], ms_dst[k], ms_dat[k], ms_red[k]);
          set_req(k, 1'b1);
        end else if (rk && ak && $urandom_range(0, 1) == 0) begin
          set_req(k, 1'b0);
        end
      end
      if (o0_if.req && !o0_if.ack && $urandom_range(0, 1) == 0)
        o0_if.ack = 1'b1;
      else if (!o0_if.req && o0_if.ack && $urandom_range(0, 1) == 0)
        o0_if.ack = 1'b0;
    end
  endtask

  initial begin
    i0_if.req = 1'b0;
    i1_if.req = 1'b0;
    o0_if.ack = 1'b0;
    set_msg(0, '0, '0, '0, '0);
    set_msg(1, '0, '0, '0, '0);
    test_reset();
    test_back_to_back();
    test_single();
    test_drop_in_req();
    test_ack_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
